// File: rtl/sipo_align.sv
// Serial-in/parallel-out deserializer that hunts for a sync word, confirms it on word
// boundaries and then delivers aligned words. Optional feature macro: SIPO_ALIGN_SYNC_DROP_EN.
module sipo_align #(
  parameter int                PWIDTH       = 20,
  parameter logic [PWIDTH-1:0] SYNC_PATTERN = 20'hE4B1D,
  parameter int                LOCK_COUNT   = 3
) (
  input  logic              i_sclk,
  input  logic              i_rst_n,
  input  logic              i_rxp,
  input  logic              i_realign,
  output logic [PWIDTH-1:0] o_pdata,
  output logic              o_pvalid,
  output logic              o_plock,
  output logic [1:0]        o_state
);

  localparam int BCW = (PWIDTH > 1) ? $clog2(PWIDTH) : 1;
  localparam logic [BCW-1:0] BC_LAST = BCW'(PWIDTH - 1);
  localparam logic [3:0]     LC      = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  logic [PWIDTH-1:0] sr_q, sr_d;
  logic [BCW-1:0]    bc_q, bc_d;
  logic [3:0]        mc_q, mc_d;
  state_e            state_q, state_d;
  logic [PWIDTH-1:0] pdata_q, pdata_d;
  logic              pvalid_q, pvalid_d;
  logic              plock_q, plock_d;
  logic [1:0]        ostate_q, ostate_d;

  logic [PWIDTH-1:0] win_s;
  logic              boundary_s;
  logic              match_s;

  // The window is what sr will hold after this edge; every pattern check looks at it.
  assign win_s      = {sr_q[PWIDTH-2:0], i_rxp};
  assign boundary_s = (bc_q == BC_LAST);
  assign match_s    = (win_s == SYNC_PATTERN);

  // Next-state logic for alignment FSM, counters and output registers.
  always_comb begin
    sr_d     = win_s;
    bc_d     = boundary_s ? {BCW{1'b0}} : (bc_q + BCW'(1));
    mc_d     = mc_q;
    state_d  = state_q;
    pdata_d  = pdata_q;
    pvalid_d = 1'b0;
    if (i_realign) begin
      state_d = HUNT;
      mc_d    = 4'd0;
    end else begin
      case (state_q)
        HUNT: begin
          if (match_s) begin
            bc_d    = {BCW{1'b0}};
            mc_d    = 4'd1;
            state_d = (LOCK_COUNT == 1) ? LOCKED : CONFIRM;
          end else begin
            state_d = HUNT;
          end
        end
        CONFIRM: begin
          if (boundary_s && match_s) begin
            if ((mc_q + 4'd1) >= LC) begin
              mc_d    = LC;
              state_d = LOCKED;
            end else begin
              mc_d = mc_q + 4'd1;
            end
          end else if (boundary_s) begin
            // No sliding re-check here: the failing window is simply abandoned.
            mc_d    = 4'd0;
            state_d = HUNT;
          end else begin
            state_d = CONFIRM;
          end
        end
        LOCKED: begin
          if (boundary_s) begin
            pdata_d = win_s;
`ifdef SIPO_ALIGN_SYNC_DROP_EN
            pvalid_d = !match_s;
`else
            pvalid_d = 1'b1;
`endif
          end else begin
            pvalid_d = 1'b0;
          end
        end
        default: begin
          state_d = HUNT;
          mc_d    = 4'd0;
        end
      endcase
    end
    plock_d  = (state_d == LOCKED);
    ostate_d = state_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_sclk) begin
    if (!i_rst_n) begin
      sr_q     <= {PWIDTH{1'b0}};
      bc_q     <= {BCW{1'b0}};
      mc_q     <= 4'd0;
      state_q  <= HUNT;
      pdata_q  <= {PWIDTH{1'b0}};
      pvalid_q <= 1'b0;
      plock_q  <= 1'b0;
      ostate_q <= 2'd0;
    end else begin
      sr_q     <= sr_d;
      bc_q     <= bc_d;
      mc_q     <= mc_d;
      state_q  <= state_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
      plock_q  <= plock_d;
      ostate_q <= ostate_d;
    end
  end

  assign o_pdata  = pdata_q;
  assign o_pvalid = pvalid_q;
  assign o_plock  = plock_q;
  assign o_state  = ostate_q;

endmodule

// File: tb/tb_sipo_align.sv
// Self-checking bench for sipo_align: directed scenarios plus randomized streams against
// a bit-history reference model.
module tb_sipo_align;
  localparam int          PW   = 20;
  localparam logic [19:0] SYNC = 20'hE4B1D;
  localparam int          LC   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxp = 1'b0;
  logic          realign = 1'b0;
  logic [PW-1:0] pdata;
  logic          pvalid;
  logic          plock;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            hist[$];
  int            m_mode = 0;
  int            m_cnt = 0;
  int            m_anchor = -1;
  int            m_edge = 0;
  logic [PW-1:0] m_pdata = '0;
  bit            m_pvalid = 1'b0;
  int            strobes = 0;

  sipo_align #(.PWIDTH(PW), .SYNC_PATTERN(SYNC), .LOCK_COUNT(LC)) dut (
    .i_sclk(clk), .i_rst_n(rst_n), .i_rxp(rxp), .i_realign(realign),
    .o_pdata(pdata), .o_pvalid(pvalid), .o_plock(plock), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] window();
    logic [63:0] w = 64'd0;
    for (int i = 0; i < PW; i++) begin
      int idx = hist.size() - PW + i;
      w = w * 2 + ((idx >= 0) ? 64'(hist[idx]) : 64'd0);
    end
    return w[PW-1:0];
  endfunction

  task automatic model_edge(input bit b, input bit rl, input bit rst);
    logic [PW-1:0] w;
    bit bnd;
    if (rst) begin
      hist.delete();
      m_mode = 0; m_cnt = 0; m_anchor = -1; m_edge = 0;
      m_pdata = '0; m_pvalid = 1'b0;
    end else begin
      hist.push_back(b);
      if (hist.size() > PW) void'(hist.pop_front());
      w = window();
      bnd = (m_edge > m_anchor) && (((m_edge - m_anchor) % PW) == 0);
      m_pvalid = 1'b0;
      if (rl) begin
        m_mode = 0; m_cnt = 0;
      end else if (m_mode == 0) begin
        if (w == SYNC) begin
          m_anchor = m_edge; m_cnt = 1; m_mode = (LC == 1) ? 2 : 1;
        end
      end else if (m_mode == 1) begin
        if (bnd && w == SYNC) begin
          m_cnt++;
          if (m_cnt >= LC) m_mode = 2;
        end else if (bnd) begin
          m_mode = 0; m_cnt = 0;
        end
      end else if (bnd) begin
        m_pdata = w;
`ifdef SIPO_ALIGN_SYNC_DROP_EN
        m_pvalid = (w != SYNC);
`else
        m_pvalid = 1'b1;
`endif
      end
      m_edge++;
    end
  endtask

  task automatic step(input bit b, input bit rl, input bit rst);
    rxp = b; realign = rl; rst_n = !rst;
    @(posedge clk);
    model_edge(b, rl, rst);
    #1;
    check_eq("pvalid", pvalid, m_pvalid);
    check_eq("plock", plock, (m_mode == 2));
    check_eq("state", state, m_mode);
    check_eq("pdata", pdata, m_pdata);
    if (pvalid) strobes++;
  endtask

  task automatic send_word(input logic [PW-1:0] wd, input bit rl_last);
    for (int i = PW - 1; i >= 0; i--) step(wd[i], rl_last && (i == 0), 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(i[0], 1'b0, 1'b1);
  endtask

  initial begin
    logic [PW-1:0] rw;
    // Reset with toggling data
    do_reset(4);
    check_eq("rst_state", state, 2'd0);
    check_eq("rst_pdata", pdata, 20'h0);
    step(1'b1, 1'b0, 1'b0);
    check_eq("rel_plock", plock, 1'b0);
    do_reset(2);

    // Acquisition: 7 junk bits, 3 syncs, then data
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0);
    send_word(SYNC, 1'b0);
    check_eq("A_confirm", state, 2'd1);
    send_word(SYNC, 1'b0);
    send_word(SYNC, 1'b0);
    check_eq("A_locked", state, 2'd2);
    check_eq("A_plock", plock, 1'b1);
    strobes = 0;
    send_word(20'h12345, 1'b0);
    check_eq("A_pdata", pdata, 20'h12345);
    check_eq("A_pvalid", pvalid, 1'b1);
    check_eq("A_strobes", strobes, 1);

    // Locked stream containing a sync word
    strobes = 0;
    send_word(20'hABCDE, 1'b0);
    send_word(SYNC, 1'b0);
    check_eq("D_mid_pdata", pdata, SYNC);
    send_word(20'h54321, 1'b0);
`ifdef SIPO_ALIGN_SYNC_DROP_EN
    check_eq("D_strobes", strobes, 2);
`else
    check_eq("D_strobes", strobes, 3);
`endif

    // Realign on a locked boundary edge, then relock
    send_word(20'h0F0F0, 1'b1);
    check_eq("R_pvalid", pvalid, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("R_plock", plock, 1'b0);
    for (int i = 0; i < 19; i++) step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_word(SYNC, 1'b0);
    check_eq("R_relock", plock, 1'b1);
    send_word(20'h2468A, 1'b0);
    check_eq("R_pdata", pdata, 20'h2468A);

    // One-cycle reset mid-word while locked
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check_eq("S_plock", plock, 1'b0);
    check_eq("S_pvalid", pvalid, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_word(SYNC, 1'b0);
    send_word(20'h13579, 1'b0);
    check_eq("S_pdata", pdata, 20'h13579);

    // Sync, sync, then a bad word returns to HUNT without any strobe
    do_reset(2);
    strobes = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    send_word(SYNC, 1'b0);
    send_word(SYNC, 1'b0);
    send_word(20'h00000, 1'b0);
    check_eq("C_hunt", state, 2'd0);
    check_eq("C_strobes", strobes, 0);

    // Randomized streams: sync-heavy words, slips, realigns and rare resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) < 5) begin
        int slip = $urandom_range(1, 7);
        for (int i = 0; i < slip; i++) step(1'($urandom), 1'b0, 1'b0);
      end
      if ($urandom_range(0, 299) == 0) do_reset(1);
      rw = ($urandom_range(0, 99) < 45) ? SYNC : PW'($urandom);
      send_word(rw, $urandom_range(0, 99) < 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sipo_align.md
Name: sipo_align

Overview:
- Serial-in/parallel-out deserializer with word alignment.
- Sits directly downstream of the serializer in the simple_serdes library.
- Clocked by the forwarded serial clock, which is the transmitter's complement pin in clock-forwarding mode.
- Receives msbit-first serial data, finds the word boundary by hunting for a sync pattern, confirms it, then delivers aligned parallel words with a one-cycle valid strobe and a lock flag.

Parameters:
- PWIDTH, 20, parallel bits per word; legal range 4..64.
- SYNC_PATTERN, 20'hE4B1D, PWIDTH-bit alignment word, transmitted msbit first.
- LOCK_COUNT, 3, consecutive on-boundary sync matches needed to declare lock; legal range 1..15.

Ports:
- i_sclk  input  1  serial clock; all logic on posedge.
- i_rst_n  input  1  reset; synchronous, active-low.
- i_rxp  input  1  serial data; sampled on posedge i_sclk.
- i_realign  input  1  single-cycle request to drop lock and re-hunt.
- o_pdata  output  PWIDTH  aligned parallel word; first-received bit at [PWIDTH-1].
- o_pvalid  output  1  one-cycle strobe; o_pdata is valid this cycle.
- o_plock  output  1  high while the FSM is in LOCKED.
- o_state  output  2  FSM state encoding: HUNT=0, CONFIRM=1, LOCKED=2.

Behaviour:
- Reset: i_rst_n sampled low at posedge gives the following values at the next edge:
  - shift register = 0, bit counter = 0, match count = 0, state = HUNT.
  - o_pdata = 0, o_pvalid = 0, o_plock = 0, o_state = 0.
  - Reset mid-word or while locked discards everything.
- Shift register sr shifts left every cycle, with i_rxp entering at bit 0.
- Compare window w = {sr[PWIDTH-2:0], i_rxp}: the value sr will hold after this edge. All pattern checks use w.
- Bit counter bc counts 0..PWIDTH-1 and wraps to 0. A "boundary edge" is any edge where bc == PWIDTH-1.
- HUNT:
  - The window is checked every edge.
  - On w == SYNC_PATTERN: bc <= 0, match count <= 1, and the next state depends on LOCK_COUNT:
    - LOCK_COUNT == 1: go straight to LOCKED.
    - Otherwise: go to CONFIRM.
  - No o_pvalid is issued in HUNT.
- CONFIRM:
  - The window is checked only on boundary edges.
  - Match: increment match count; when it reaches LOCK_COUNT, go to LOCKED.
  - Mismatch: go to HUNT. The mismatching window is not re-checked for a sliding match on that edge.
- LOCKED:
  - On every boundary edge: o_pdata <= w and o_pvalid <= 1 for one cycle, subject to the sync-word drop rule (Optional Feature).
  - o_pvalid is 0 on all other edges.
  - Lock is held until reset or i_realign.
- Latency: the last bit of a word presented on i_rxp at posedge N appears on o_pdata/o_pvalid after posedge N, i.e. visible in cycle N+1. The strobe repeats every PWIDTH cycles.
- The first LOCKED word is the word after the LOCK_COUNT-th sync match.
- i_realign high at posedge:
  - state <= HUNT, match count <= 0, o_pvalid <= 0, o_plock drops the next cycle.
  - sr keeps shifting.
  - Realign has priority over a simultaneous sync match or boundary output on the same edge.
- o_plock and o_state are registered and derived from the state register.
- Widths:
  - bc is $clog2(PWIDTH) bits.
  - match count is 4 bits, saturating at LOCK_COUNT.

Optional Feature:
- Macro: SIPO_ALIGN_SYNC_DROP_EN.
- Defined: in LOCKED, boundary words equal to SYNC_PATTERN are treated as idle fill. o_pvalid stays 0 for that word; o_pdata still updates.
- Undefined: every boundary word in LOCKED, including sync words, is delivered with o_pvalid = 1.

Test Plan:
- Reset with i_rxp toggling -> all outputs 0 through reset and on the first edge after release. o_state = 0.
- 7 junk bits, then 3 sync words (20'hE4B1D), then 20'h12345 -> o_state reaches 1 after the 27th bit and 2 after the 67th bit.
  - o_plock = 1 from then on.
  - o_pdata = 20'h12345 with o_pvalid = 1 one cycle after the 87th bit.
  - Exactly one strobe per 20 cycles.
- Sync, sync, then 20'h00000 -> returns to HUNT on that boundary (o_state = 0); no o_pvalid is ever asserted.
- Locked stream: 20'hABCDE, sync, 20'h54321 -> macro defined: 2 strobes, sync word suppressed. Undefined: 3 strobes, middle o_pdata = 20'hE4B1D.
- i_realign pulse coinciding with a LOCKED boundary edge -> no o_pvalid on that edge. o_plock = 0 the next cycle. Relock after 3 further sync words.
- i_rst_n low for 1 cycle mid-word while locked -> o_plock = 0 and o_pvalid = 0 the next cycle; full re-acquisition is required.
